// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The master side drives operands and accepts results; the slave side is the adder.
interface pipelined_add_sub_if #(
   parameter int DATA_SIZE = 16
);

   logic                 valid_in;
   logic                 ready_out;
   logic [DATA_SIZE-1:0] a_in;
   logic [DATA_SIZE-1:0] b_in;
   logic                 carry_in;
   logic                 sub_in;
   logic                 valid_out;
   logic                 ready_in;
   logic [DATA_SIZE-1:0] result_out;
   logic                 carry_out;
   logic                 overflow_out;

   modport master (
      output valid_in, a_in, b_in, carry_in, sub_in, ready_in,
      input  ready_out, valid_out, result_out, carry_out, overflow_out
   );

   modport slave (
      input  valid_in, a_in, b_in, carry_in, sub_in, ready_in,
      output ready_out, valid_out, result_out, carry_out, overflow_out
   );

endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: a DATA_SIZE-bit add is split into CHUNK_SIZE-bit
// slices, one slice per pipeline stage, with the carry rippling through registers.
// Every stage carries the whole operand pair and the partially built sum, so the
// upper operand slices travel with the beat and the finished lower slices stay
// aligned until the last stage presents the complete result.
// Optional feature: define OVERFLOW_DETECT_EN to get signed overflow detection;
// without it overflow_out is tied low and no sign-tracking flop exists.
module pipelined_add_sub #(
   parameter int DATA_SIZE  = 16,
   parameter int CHUNK_SIZE = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   pipelined_add_sub_if.slave  bus
);

   localparam int STAGES = DATA_SIZE / CHUNK_SIZE;

   logic [STAGES-1:0]    valid_q, valid_d;
   logic [STAGES-1:0]    carry_q, carry_d;
   logic [DATA_SIZE-1:0] a_q   [STAGES];
   logic [DATA_SIZE-1:0] a_d   [STAGES];
   logic [DATA_SIZE-1:0] b_q   [STAGES];
   logic [DATA_SIZE-1:0] b_d   [STAGES];
   logic [DATA_SIZE-1:0] sum_q [STAGES];
   logic [DATA_SIZE-1:0] sum_d [STAGES];

   logic                 adv;
   logic [DATA_SIZE-1:0] b_eff;
   logic [CHUNK_SIZE:0]  slice;

`ifdef OVERFLOW_DETECT_EN
   logic ovf_q, ovf_d;
`endif

   function automatic logic [CHUNK_SIZE:0] add_slice(
      input logic [CHUNK_SIZE-1:0] x,
      input logic [CHUNK_SIZE-1:0] y,
      input logic                  cin
   );
      return {1'b0, x} + {1'b0, y} + {{CHUNK_SIZE{1'b0}}, cin};
   endfunction

   // Next-state of every stage: the whole pipe either advances together or holds.
   always_comb begin
      adv     = ~valid_q[STAGES-1] | bus.ready_in;
      b_eff   = bus.sub_in ? ~bus.b_in : bus.b_in;
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      slice   = '0;
      if (adv) begin
         slice                       = add_slice(bus.a_in[CHUNK_SIZE-1:0], b_eff[CHUNK_SIZE-1:0], bus.carry_in);
         valid_d[0]                  = bus.valid_in;
         a_d[0]                      = bus.a_in;
         b_d[0]                      = b_eff;
         sum_d[0]                    = '0;
         sum_d[0][CHUNK_SIZE-1:0]    = slice[CHUNK_SIZE-1:0];
         carry_d[0]                  = slice[CHUNK_SIZE];
         for (int k = 1; k < STAGES; k++) begin
            slice                            = add_slice(a_q[k-1][k*CHUNK_SIZE +: CHUNK_SIZE],
                                                         b_q[k-1][k*CHUNK_SIZE +: CHUNK_SIZE],
                                                         carry_q[k-1]);
            valid_d[k]                       = valid_q[k-1];
            a_d[k]                           = a_q[k-1];
            b_d[k]                           = b_q[k-1];
            sum_d[k]                         = sum_q[k-1];
            sum_d[k][k*CHUNK_SIZE +: CHUNK_SIZE] = slice[CHUNK_SIZE-1:0];
            carry_d[k]                       = slice[CHUNK_SIZE];
         end
      end
   end

`ifdef OVERFLOW_DETECT_EN
   // Signed overflow judged on the operands entering the last stage and its finished sum.
   always_comb begin
      ovf_d = ovf_q;
      if (adv) begin
         ovf_d = (a_d[STAGES-1][DATA_SIZE-1] == b_d[STAGES-1][DATA_SIZE-1]) &
                 (sum_d[STAGES-1][DATA_SIZE-1] != a_d[STAGES-1][DATA_SIZE-1]);
      end
   end

   // Overflow flag registered alongside the result it describes.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.overflow_out = ovf_q;
`else
   assign bus.overflow_out = 1'b0;
`endif

   // Stage registers; reset drops every in-flight beat and clears the visible result.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign bus.ready_out  = adv;
   assign bus.valid_out  = valid_q[STAGES-1];
   assign bus.result_out = sum_q[STAGES-1];
   assign bus.carry_out  = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed-vector bench for pipelined_add_sub (DATA_SIZE=16, CHUNK_SIZE=4, four stages).
// Expected overflow follows OVERFLOW_DETECT_EN when the bench is built with it.
module tb_pipelined_add_sub;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

`ifdef OVERFLOW_DETECT_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   pipelined_add_sub_if #(.DATA_SIZE(16)) bus ();

   pipelined_add_sub #(.DATA_SIZE(16), .CHUNK_SIZE(4)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports it if observed differs from expected.
   task automatic check_output(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one beat on the operand side.
   task automatic apply_stimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
      bus.valid_in = v;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.carry_in = cin;
      bus.sub_in   = sub;
   endtask

   // Advance one rising edge and return on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single beat through an otherwise empty pipe, checking latency and result.
   task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub,
                             input logic [15:0] res, input logic c, input logic o);
      apply_stimulus(1'b1, a, b, cin, sub);
      step();
      apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      check_output({tag, "_lat1"}, {16'h0, bus.valid_out}, 17'h0);
      step();
      step();
      check_output({tag, "_lat3"}, {16'h0, bus.valid_out}, 17'h0);
      step();
      check_output({tag, "_valid"}, {16'h0, bus.valid_out}, 17'h1);
      check_output({tag, "_res"}, {1'b0, bus.result_out}, {1'b0, res});
      check_output({tag, "_carry"}, {16'h0, bus.carry_out}, {16'h0, c});
      check_output({tag, "_ovf"}, {16'h0, bus.overflow_out}, {16'h0, o});
      step();
      check_output({tag, "_drain"}, {16'h0, bus.valid_out}, 17'h0);
   endtask

   logic [15:0] va   [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'hABCD, 16'h0F0F, 16'h4000, 16'h1000};
   logic [15:0] vb   [8] = '{16'h1111, 16'hFFFF, 16'h0001, 16'h0001, 16'h1234, 16'hF0F1, 16'h4000, 16'h2000};
   logic        vcin [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        vsub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [15:0] vres [8] = '{16'h2345, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'hBE01, 16'h0000, 16'h8000, 16'hF000};
   logic        vc   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic        vo   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      bus.ready_in = 1'b1;
      rst = 1'b1;
      step();
      step();
      check_output("rst_valid", {16'h0, bus.valid_out}, 17'h0);
      check_output("rst_result", {1'b0, bus.result_out}, 17'h0);
      check_output("rst_carry", {16'h0, bus.carry_out}, 17'h0);
      check_output("rst_ovf", {16'h0, bus.overflow_out}, 17'h0);
      check_output("rst_ready", {16'h0, bus.ready_out}, 17'h1);
      rst = 1'b0;
      step();

      // Full ripple, borrow case, and signed overflow.
      run_single("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_single("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_single("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);

      // Eight back-to-back beats at full throughput.
      for (int i = 0; i < 11; i++) begin
         if (i < 8) apply_stimulus(1'b1, va[i], vb[i], vcin[i], vsub[i]);
         else       apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         check_output($sformatf("b2b_ready%0d", i), {16'h0, bus.ready_out}, 17'h1);
         step();
         if (i >= 3) begin
            check_output($sformatf("b2b_valid%0d", i - 3), {16'h0, bus.valid_out}, 17'h1);
            check_output($sformatf("b2b_res%0d", i - 3), {bus.carry_out, bus.result_out},
                         {vc[i - 3], vres[i - 3]});
            check_output($sformatf("b2b_ovf%0d", i - 3), {16'h0, bus.overflow_out},
                         {16'h0, vo[i - 3] & OVF_ON});
         end
      end
      step();
      check_output("b2b_drain", {16'h0, bus.valid_out}, 17'h0);

      // Stall for three cycles with the next beat waiting at the input.
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(1'b1, 16'(i), 16'(i), 1'b0, 1'b0);
         step();
      end
      apply_stimulus(1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0);
      bus.ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_output($sformatf("stall_ready%0d", i), {16'h0, bus.ready_out}, 17'h0);
         step();
         check_output($sformatf("stall_valid%0d", i), {16'h0, bus.valid_out}, 17'h1);
         check_output($sformatf("stall_res%0d", i), {bus.carry_out, bus.result_out}, 17'h00002);
      end
      bus.ready_in = 1'b1;
      step();
      apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      check_output("stall_out1", {bus.valid_out, bus.result_out}, 17'h10004);
      step();
      check_output("stall_out2", {bus.valid_out, bus.result_out}, 17'h10006);
      step();
      check_output("stall_out3", {bus.valid_out, bus.result_out}, 17'h10008);
      step();
      check_output("stall_out4", {bus.valid_out, bus.result_out}, 17'h1000A);
      step();
      check_output("stall_drain", {16'h0, bus.valid_out}, 17'h0);

      // Reset with three beats in flight, then a fresh beat.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 16'h0100, 16'(i + 1), 1'b0, 1'b0);
         step();
      end
      apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("flush_valid%0d", i), {16'h0, bus.valid_out}, 17'h0);
         step();
      end
      run_single("post_rst", 16'h0020, 16'h0003, 1'b0, 1'b0, 16'h0023, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
